// File: rtl/cache_rw_arbiter.sv
// cache_rw_arbiter: shares one cache_rw line-transfer port between an
// instruction-side requester (m0) and a data-side requester (m1).
// One transaction is in flight at a time. Ties are broken round-robin, and
// the granted request is latched so the downstream port sees stable fields.
module cache_rw_arbiter (
  input  logic         clk,
  input  logic         rst,
  // instruction-side requester
  input  logic         i_m0_valid,
  input  logic         i_m0_op,
  input  logic [63:0]  i_m0_addr,
  input  logic [511:0] i_m0_wdata,
  input  logic [1:0]   i_m0_size,
  input  logic [7:0]   i_m0_blks,
  output logic         o_m0_ready,
  output logic [511:0] o_m0_rdata,
  // data-side requester
  input  logic         i_m1_valid,
  input  logic         i_m1_op,
  input  logic [63:0]  i_m1_addr,
  input  logic [511:0] i_m1_wdata,
  input  logic [1:0]   i_m1_size,
  input  logic [7:0]   i_m1_blks,
  output logic         o_m1_ready,
  output logic [511:0] o_m1_rdata,
  // shared downstream port
  output logic         o_axi_valid,
  output logic         o_axi_op,
  output logic [63:0]  o_axi_addr,
  output logic [511:0] o_axi_wdata,
  output logic [1:0]   o_axi_size,
  output logic [7:0]   o_axi_blks,
  input  logic         i_axi_ready,
  input  logic [511:0] i_axi_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_last_m1;   // 1 when m1 received the most recent grant
  logic         r_grant_m1;  // owner of the transaction in flight
  logic         r_axi_valid;
  logic         r_axi_op;
  logic [63:0]  r_axi_addr;
  logic [511:0] r_axi_wdata;
  logic [1:0]   r_axi_size;
  logic [7:0]   r_axi_blks;
  logic         r_m0_ready;
  logic         r_m1_ready;
  logic [511:0] r_m0_rdata;
  logic [511:0] r_m1_rdata;

  logic         w_any_valid;
  logic         w_pick_m1;
  logic         w_req_op;
  logic [63:0]  w_req_addr;
  logic [511:0] w_req_wdata;
  logic [1:0]   w_req_size;
  logic [7:0]   w_req_blks;

  // m1 wins when it is the only requester, or on a tie when m0 went last.
  assign w_any_valid = i_m0_valid | i_m1_valid;
  assign w_pick_m1   = i_m1_valid & (~i_m0_valid | ~r_last_m1);

  assign w_req_op    = w_pick_m1 ? i_m1_op    : i_m0_op;
  assign w_req_addr  = w_pick_m1 ? i_m1_addr  : i_m0_addr;
  assign w_req_wdata = w_pick_m1 ? i_m1_wdata : i_m0_wdata;
  assign w_req_size  = w_pick_m1 ? i_m1_size  : i_m0_size;
  assign w_req_blks  = w_pick_m1 ? i_m1_blks  : i_m0_blks;

  // Grant, hold and complete one transaction; every output is a register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // reads the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_last_m1   <= 1'b0;
      r_grant_m1  <= 1'b0;
      r_axi_valid <= 1'b0;
      r_axi_op    <= 1'b0;
      r_axi_addr  <= '0;
      r_axi_wdata <= '0;
      r_axi_size  <= '0;
      r_axi_blks  <= '0;
      r_m0_ready  <= 1'b0;
      r_m1_ready  <= 1'b0;
      // NOTE: the wide line registers are reset too, because requesters may
      // observe o_mX_rdata right after reset and it must read as zero.
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_state     <= BUSY;
            r_grant_m1  <= w_pick_m1;
            r_last_m1   <= w_pick_m1;
            r_axi_valid <= 1'b1;
            r_axi_op    <= w_req_op;
            r_axi_addr  <= w_req_addr;
            r_axi_wdata <= w_req_wdata;
            r_axi_size  <= w_req_size;
            r_axi_blks  <= w_req_blks;
          end
        end
        BUSY: begin
          if (i_axi_ready) begin
            r_state     <= RESP;
            r_axi_valid <= 1'b0;
            r_m0_ready  <= ~r_grant_m1;
            r_m1_ready  <= r_grant_m1;
            if (!r_axi_op) begin
              if (r_grant_m1) r_m1_rdata <= i_axi_rdata;
              else            r_m0_rdata <= i_axi_rdata;
            end
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_axi_valid = r_axi_valid;
  assign o_axi_op    = r_axi_op;
  assign o_axi_addr  = r_axi_addr;
  assign o_axi_wdata = r_axi_wdata;
  assign o_axi_size  = r_axi_size;
  assign o_axi_blks  = r_axi_blks;
  assign o_m0_ready  = r_m0_ready;
  assign o_m1_ready  = r_m1_ready;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: doc/cache_rw_arbiter.md
CACHE_RW_ARBITER -- requirements
Module: cache_rw_arbiter

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_m0_valid  input  1  instruction-side line request (held until o_m0_ready).
REQ-005 i_m0_op  input  1  0 read, 1 write.
REQ-006 i_m0_addr  input  64  line address.
REQ-007 i_m0_wdata  input  512  line write data.
REQ-008 i_m0_size  input  2  beat size code.
REQ-009 i_m0_blks  input  8  beat count code.
REQ-010 o_m0_ready  output  1  one-cycle completion pulse to m0.
REQ-011 o_m0_rdata  output  512  registered read line for m0.
REQ-012 i_m1_valid/op/addr/wdata/size/blks, o_m1_ready, o_m1_rdata: data-side port, widths and meanings identical to m0.
REQ-013 o_axi_valid  output  1  downstream request.
REQ-014 o_axi_op, o_axi_addr, o_axi_wdata, o_axi_size, o_axi_blks  outputs  1/64/512/2/8  latched request fields.
REQ-015 i_axi_ready  input  1  downstream completion pulse.
REQ-016 i_axi_rdata  input  512  downstream read line, valid while i_axi_ready=1.

Function
REQ-017 The block SHALL share one cache_rw line-transfer port between requesters m0 and m1, one transaction at a time.
REQ-018 FSM states SHALL be IDLE, BUSY, RESP; reset state IDLE.
REQ-019 IDLE: if any i_mX_valid=1, SHALL grant one requester, latch its op/addr/wdata/size/blks into the o_axi_* registers, record grant, go to BUSY at the next edge; else stay IDLE.
REQ-020 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; when one valid, grant it.
REQ-021 The last-grant register SHALL reset to m0, so m1 wins the first tie after reset.
REQ-022 BUSY: o_axi_valid SHALL be 1 and o_axi_* fields SHALL hold constant regardless of requester input changes.
REQ-023 BUSY with i_axi_ready=1: SHALL go to RESP, drop o_axi_valid next cycle, and, if op=0, load i_axi_rdata into the granted o_mX_rdata.
REQ-024 Writes (op=1) SHALL leave both o_mX_rdata unchanged.
REQ-025 RESP: o_mX_ready SHALL be 1 for the granted requester only, for exactly one cycle; next state IDLE.
REQ-026 Latency: valid sampled in IDLE at edge t -> o_axi_valid=1 from t+1; i_axi_ready at edge u -> o_mX_ready=1 in cycle u+1; IDLE again at u+2.
REQ-027 Requesters SHALL deassert valid at the edge where they sample their ready; the arbiter MAY regrant any valid present in IDLE.
REQ-028 i_axi_ready outside BUSY SHALL be ignored.
REQ-029 Requester deasserting valid during BUSY SHALL NOT abort the transaction; it completes and ready still pulses.
REQ-030 The non-granted requester's valid SHALL be held pending without loss and served at the next IDLE.
REQ-031 o_m0_ready and o_m1_ready SHALL never both be 1.

Reset
REQ-032 On rst=1: state IDLE, last-grant m0, o_axi_valid=0, o_m0_ready=o_m1_ready=0, o_axi_op/addr/wdata/size/blks=0, o_m0_rdata=o_m1_rdata=0.
REQ-033 rst during BUSY or RESP SHALL abandon the transaction without issuing ready; a later i_axi_ready SHALL be ignored.

Verification
REQ-034 m0 read addr 0x8000_0040 alone; i_axi_ready after 3 cycles with rdata 0xA5.. -> o_axi_addr=0x8000_0040, o_axi_valid 3 cycles, o_m0_ready one pulse, o_m0_rdata=0xA5.., o_m1_rdata=0.
REQ-035 m0 and m1 valid same cycle right after reset -> m1 granted first, then m0; o_m1_ready precedes o_m0_ready; exactly one ready each.
REQ-036 Both requesters continuously re-request 4 times -> grants alternate m1,m0,m1,m0,...; no requester served twice consecutively while the other waits.
REQ-037 m1 write addr 0x8000_1000 wdata 0x1234..; change m1 inputs during BUSY -> o_axi_* fields unchanged until completion; o_m1_rdata unchanged.
REQ-038 rst pulsed mid-BUSY, then i_axi_ready -> no o_mX_ready pulse, all outputs zero, FSM IDLE.
REQ-039 i_axi_ready asserted while IDLE with no valid -> no state change, no ready pulse.
